// File: rtl/l3_core_arbiter.sv
// Round-robin arbiter/sequencer giving N_CORE cores one-at-a-time access to a shared L3 port.
// Latency: grant edge -> ISSUE, ack one cycle after the mem_ready edge; min 3 cycles per transaction.
// Backpressure: losers and the granted core see busy until their ack; a stuck memory ends in a timeout.
module l3_core_arbiter #(
  parameter int N_CORE  = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [N_CORE-1:0]          req,
  input  logic [N_CORE-1:0]          we,
  input  logic [N_CORE*ADDR_W-1:0]   addr,
  input  logic [N_CORE*DATA_W-1:0]   wdata,
  output logic [N_CORE-1:0]          ack,
  output logic                       err,
  output logic [DATA_W-1:0]          rdata,
  output logic [N_CORE-1:0]          busy,
  output logic [$clog2(N_CORE)-1:0]  grant_id,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ready
);

  localparam int GW = $clog2(N_CORE);
  // The counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              win_vld;
  logic [GW-1:0]     win_idx;
  logic [GW-1:0]     cand;

  // Round-robin search: first requesting core after the last granted one
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N_CORE; i++) begin
      cand = GW'((int'(last_q) + i) % N_CORE);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Transaction sequencing: IDLE grants and latches, ISSUE waits for ready or timeout, DONE acks
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_ISSUE;
          grant_d = win_idx;
          cnt_d   = '0;
          for (int i = 0; i < N_CORE; i++) begin
            if (win_idx == GW'(i)) begin
              we_d    = we[i];
              addr_d  = addr[i*ADDR_W +: ADDR_W];
              wdata_d = wdata[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          state_d = ST_DONE;
          if (!we_q) rdata_d = mem_rdata;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = grant_q;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset leaves core 0 with first priority and aborts any open access
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_CORE - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // One-hot completion pulse to the granted core while in DONE
  always_comb begin
    ack = '0;
    if (state_q == ST_DONE) ack[grant_q] = 1'b1;
  end

  assign busy      = req & ~ack;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_q;
  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
